// File: rtl/pon_burst_scheduler.sv
// Round-robin TDMA burst scheduler for the shared 10G TX AXI-stream.
// Each granted slot emits preamble words, the sync word, then the granted source's payload.
module pon_burst_scheduler #(
  parameter int          N_SRC         = 4,
  parameter logic [31:0] PREAMBLE_WORD = 32'hAAAAAAAA,
  parameter logic [31:0] SYNC_WORD     = 32'h05560556
) (
  input  logic                  tx_axis_usrclk,
  input  logic                  reset_in,
  input  logic                  enable,
  input  logic [15:0]           preamble_length,
  input  logic [15:0]           burst_length,
  input  logic [31:0]           burst_period,
  input  logic [N_SRC-1:0]      req,
  output logic [N_SRC-1:0]      grant,
  input  logic [32*N_SRC-1:0]   s_axis_tdata,
  input  logic [N_SRC-1:0]      s_axis_tvalid,
  output logic [N_SRC-1:0]      s_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [3:0]            m_axis_tkeep,
  output logic                  m_axis_tuser,
  output logic                  burst_active,
  output logic [31:0]           burst_count,
  output logic                  overrun,
  output logic                  underrun_err,
  output logic                  config_err
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [2:0] {IDLE, ARB, PREAMBLE, SYNC, PAYLOAD} state_t;

  state_t           state;
  state_t           next_state;
  logic [31:0]      slot_cnt;
  logic [31:0]      last_slot;
  logic             slot_zero;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] cand;
  logic             arb_found;
  logic [15:0]      word_cnt;
  logic [15:0]      pre_len_q;
  logic [15:0]      burst_len_q;
  logic [N_SRC-1:0] grant_q;
  logic             grant_now;
  logic             busy;
  logic             hs;
  logic             end_burst;
  logic             underrun_now;

  // A zero period behaves as a one-cycle slot; slot_cnt is frozen at 0 while disabled.
  assign last_slot = (burst_period == 32'd0) ? 32'd0 : burst_period - 32'd1;
  assign slot_zero = enable && (slot_cnt == 32'd0);

  always_ff @(posedge tx_axis_usrclk) begin
    if (reset_in || !enable) begin
      slot_cnt <= 32'd0;
    end else if (slot_cnt >= last_slot) begin
      slot_cnt <= 32'd0;
    end else begin
      slot_cnt <= slot_cnt + 32'd1;
    end
  end

  // Cyclic search from ptr+1; iterating downwards lets the nearest requester win.
  always_comb begin
    arb_idx   = ptr;
    arb_found = 1'b0;
    cand      = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr) + i) % N_SRC);
      if (req[cand]) begin
        arb_idx   = cand;
        arb_found = 1'b1;
      end
    end
  end

  assign busy         = (state == PREAMBLE) || (state == SYNC) || (state == PAYLOAD);
  assign hs           = m_axis_tvalid && m_axis_tready;
  assign end_burst    = hs && m_axis_tlast;
  assign underrun_now = (state == PAYLOAD) && !s_axis_tvalid[ptr];

  always_ff @(posedge tx_axis_usrclk) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A burst ending on a slot boundary re-arbitrates in the same cycle.
  always_comb begin
    next_state = state;
    grant_now  = 1'b0;
    case (state)
      IDLE:     if (enable) next_state = ARB;
      ARB: begin
        if (!enable) begin
          next_state = IDLE;
        end else if (slot_zero && arb_found) begin
          grant_now = 1'b1;
        end
      end
      PREAMBLE: if (hs && (word_cnt == pre_len_q - 16'd1)) next_state = SYNC;
      SYNC:     if (hs && (burst_len_q != 16'd0)) next_state = PAYLOAD;
      default:  ;
    endcase
    if (end_burst) begin
      next_state = enable ? ARB : IDLE;
      grant_now  = slot_zero && arb_found;
    end
    if (grant_now) begin
      next_state = (preamble_length == 16'd0) ? SYNC : PREAMBLE;
    end
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state)
      PREAMBLE: begin
        m_axis_tdata  = PREAMBLE_WORD;
        m_axis_tvalid = 1'b1;
      end
      SYNC: begin
        m_axis_tdata  = SYNC_WORD;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (burst_len_q == 16'd0);
      end
      PAYLOAD: begin
        m_axis_tdata       = s_axis_tdata[ptr*32 +: 32];
        m_axis_tvalid      = s_axis_tvalid[ptr];
        m_axis_tlast       = (word_cnt == burst_len_q - 16'd1);
        s_axis_tready[ptr] = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign m_axis_tkeep = m_axis_tvalid ? 4'hF : 4'h0;
  assign m_axis_tuser = 1'b0;
  assign burst_active = busy;
  assign grant        = grant_q;
  assign config_err   = ({17'd0, preamble_length} + {17'd0, burst_length} + 33'd1)
                        >= {1'b0, burst_period};

  // ptr doubles as the granted index for the payload mux while a burst runs.
  always_ff @(posedge tx_axis_usrclk) begin
    if (reset_in) begin
      ptr          <= IDX_W'(N_SRC - 1);
      grant_q      <= '0;
      word_cnt     <= 16'd0;
      pre_len_q    <= 16'd0;
      burst_len_q  <= 16'd0;
      burst_count  <= 32'd0;
      overrun      <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      overrun <= slot_zero && busy && !end_burst;
      if (underrun_now) underrun_err <= 1'b1;
      if (end_burst) begin
        burst_count <= burst_count + 32'd1;
        grant_q     <= '0;
      end
      if (grant_now) begin
        ptr         <= arb_idx;
        grant_q     <= N_SRC'(1) << arb_idx;
        pre_len_q   <= preamble_length;
        burst_len_q <= burst_length;
        word_cnt    <= 16'd0;
      end else if (hs) begin
        if ((state == PREAMBLE) && (word_cnt == pre_len_q - 16'd1)) begin
          word_cnt <= 16'd0;
        end else if (state == SYNC) begin
          word_cnt <= 16'd0;
        end else begin
          word_cnt <= word_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pon_burst_scheduler.sv
// Scoreboard bench for pon_burst_scheduler: expected beats are queued at stimulus time
// and a forked monitor pops and compares them on every output handshake.
module tb_pon_burst_scheduler;

  localparam int N_SRC = 4;
  localparam logic [31:0] PRE_W  = 32'hAAAAAAAA;
  localparam logic [31:0] SYNC_W = 32'h05560556;

  typedef struct {
    logic [31:0]      data;
    logic             last;
    logic [N_SRC-1:0] grant;
  } beat_t;

  logic                tx_axis_usrclk = 1'b0;
  logic                reset_in;
  logic                enable;
  logic [15:0]         preamble_length;
  logic [15:0]         burst_length;
  logic [31:0]         burst_period;
  logic [N_SRC-1:0]    req;
  logic [N_SRC-1:0]    grant;
  logic [32*N_SRC-1:0] s_axis_tdata;
  logic [N_SRC-1:0]    s_axis_tvalid;
  logic [N_SRC-1:0]    s_axis_tready;
  logic [31:0]         m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tlast;
  logic [3:0]          m_axis_tkeep;
  logic                m_axis_tuser;
  logic                burst_active;
  logic [31:0]         burst_count;
  logic                overrun;
  logic                underrun_err;
  logic                config_err;

  logic [27:0]         src_cnt [N_SRC];
  logic [N_SRC-1:0]    src_valid_en;
  logic                bp_mode;
  beat_t               exp_q[$];
  int                  exp_idx [N_SRC];
  int                  checks;
  int                  errors;
  int                  hs_cnt;
  int                  ovr_cnt;
  int                  gap_cnt;
  int                  base;
  int                  ovr_base;
  int                  gap_base;

  pon_burst_scheduler #(.N_SRC(N_SRC)) dut (
    .tx_axis_usrclk (tx_axis_usrclk),
    .reset_in       (reset_in),
    .enable         (enable),
    .preamble_length(preamble_length),
    .burst_length   (burst_length),
    .burst_period   (burst_period),
    .req            (req),
    .grant          (grant),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tuser   (m_axis_tuser),
    .burst_active   (burst_active),
    .burst_count    (burst_count),
    .overrun        (overrun),
    .underrun_err   (underrun_err),
    .config_err     (config_err)
  );

  always #5 tx_axis_usrclk = ~tx_axis_usrclk;

  // Source i emits {i+1, running word index}, advancing only on its own handshake.
  always_comb begin
    s_axis_tdata = '0;
    for (int i = 0; i < N_SRC; i++) s_axis_tdata[i*32 +: 32] = {4'(i + 1), src_cnt[i]};
  end
  assign s_axis_tvalid = src_valid_en;

  always @(posedge tx_axis_usrclk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (reset_in) src_cnt[i] <= '0;
      else if (s_axis_tvalid[i] && s_axis_tready[i]) src_cnt[i] <= src_cnt[i] + 28'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tx_axis_usrclk);
    #1;
    if (bp_mode) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic applyStimulus(input int pre, input int len, input int period,
                               input logic [N_SRC-1:0] r, input logic en);
    preamble_length = 16'(pre);
    burst_length    = 16'(len);
    burst_period    = 32'(period);
    req             = r;
    enable          = en;
  endtask

  task automatic pushBurst(input int src, input int pre, input int len);
    beat_t b;
    b.grant = 4'b0001 << src;
    for (int k = 0; k < pre; k++) begin
      b.data = PRE_W;
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    b.data = SYNC_W;
    b.last = (len == 0);
    exp_q.push_back(b);
    for (int k = 0; k < len; k++) begin
      b.data = {4'(src + 1), 28'(exp_idx[src])};
      b.last = (k == len - 1);
      exp_q.push_back(b);
      exp_idx[src]++;
    end
  endtask

  task automatic clearModel();
    exp_q.delete();
    for (int i = 0; i < N_SRC; i++) exp_idx[i] = 0;
  endtask

  task automatic doReset();
    reset_in = 1'b1;
    enable   = 1'b0;
    req      = '0;
    step();
    step();
    reset_in = 1'b0;
    clearModel();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    checkOutput({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    checkOutput({tag, "_tdata"}, m_axis_tdata, 32'd0);
    checkOutput({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    checkOutput({tag, "_tkeep"}, 32'(m_axis_tkeep), 32'd0);
    checkOutput({tag, "_tuser"}, 32'(m_axis_tuser), 32'd0);
    checkOutput({tag, "_active"}, 32'(burst_active), 32'd0);
    checkOutput({tag, "_count"}, burst_count, 32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
    checkOutput({tag, "_underrun"}, 32'(underrun_err), 32'd0);
  endtask

  task automatic waitDrain(input int max_cycles, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic waitHs(input int target, input int max_cycles, input string name);
    int n = 0;
    while (hs_cnt < target && n < max_cycles) begin
      step();
      n++;
    end
    checkOutput(name, 32'(hs_cnt >= target), 32'd1);
  endtask

  // Pops one expected beat per handshake and checks that stalled beats hold steady.
  task automatic runMonitor();
    beat_t       e;
    logic        stall_pending = 1'b0;
    logic [31:0] stall_data = '0;
    logic        stall_last = 1'b0;
    forever begin
      @(negedge tx_axis_usrclk);
      if (reset_in) begin
        stall_pending = 1'b0;
      end else begin
        if (stall_pending) begin
          checkOutput("stall_valid", 32'(m_axis_tvalid), 32'd1);
          checkOutput("stall_data", m_axis_tdata, stall_data);
          checkOutput("stall_last", 32'(m_axis_tlast), 32'(stall_last));
        end
        stall_pending = m_axis_tvalid && !m_axis_tready;
        stall_data    = m_axis_tdata;
        stall_last    = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got data %h grant %b expected no beat",
                     m_axis_tdata, grant);
          end else begin
            e = exp_q.pop_front();
            checkOutput("tdata", m_axis_tdata, e.data);
            checkOutput("tlast", 32'(m_axis_tlast), 32'(e.last));
            checkOutput("grant", 32'(grant), 32'(e.grant));
            checkOutput("tkeep", 32'(m_axis_tkeep), 32'hF);
          end
        end
        if (overrun) ovr_cnt++;
        if (burst_active && !m_axis_tvalid) gap_cnt++;
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; hs_cnt = 0; ovr_cnt = 0; gap_cnt = 0;
    reset_in = 1'b1; enable = 1'b0; req = '0; bp_mode = 1'b0;
    preamble_length = '0; burst_length = '0; burst_period = '0;
    m_axis_tready = 1'b1; src_valid_en = '1;
    clearModel();
    fork
      runMonitor();
    join_none
    step();
    doReset();
    checkResetState("rst");
    checkOutput("cfg_err_zero_period", 32'(config_err), 32'd1);

    $display("[TB] single source, slot timing");
    applyStimulus(4, 8, 32, 4'b0001, 1'b1);
    ovr_base = ovr_cnt;
    for (int b = 0; b < 3; b++) pushBurst(0, 4, 8);
    repeat (32) step();
    checkOutput("cfg_err_ok", 32'(config_err), 32'd0);
    checkOutput("grant_before_slot", 32'(grant), 32'd0);
    checkOutput("valid_before_slot", 32'(m_axis_tvalid), 32'd0);
    step();
    checkOutput("grant_latency", 32'(grant), 32'b0001);
    checkOutput("valid_latency", 32'(m_axis_tvalid), 32'd1);
    checkOutput("first_word", m_axis_tdata, PRE_W);
    waitDrain(200, "drain_single");
    enable = 1'b0;
    checkOutput("single_count", burst_count, 32'd3);
    checkOutput("single_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
    checkOutput("single_active", 32'(burst_active), 32'd0);

    $display("[TB] round robin");
    doReset();
    applyStimulus(2, 3, 16, 4'b1011, 1'b1);
    ovr_base = ovr_cnt;
    pushBurst(0, 2, 3); pushBurst(1, 2, 3); pushBurst(3, 2, 3);
    pushBurst(0, 2, 3); pushBurst(1, 2, 3); pushBurst(3, 2, 3);
    waitDrain(200, "drain_rr");
    enable = 1'b0;
    checkOutput("rr_count", burst_count, 32'd6);
    checkOutput("rr_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

    $display("[TB] backpressure and overrun");
    doReset();
    bp_mode = 1'b1;
    applyStimulus(4, 8, 20, 4'b0001, 1'b1);
    ovr_base = ovr_cnt;
    pushBurst(0, 4, 8); pushBurst(0, 4, 8);
    waitDrain(200, "drain_bp");
    enable = 1'b0;
    bp_mode = 1'b0;
    m_axis_tready = 1'b1;
    checkOutput("bp_count", burst_count, 32'd2);
    checkOutput("bp_overrun", 32'(ovr_cnt - ovr_base), 32'd2);

    $display("[TB] zero lengths, zero period");
    doReset();
    applyStimulus(0, 0, 0, 4'b0101, 1'b1);
    ovr_base = ovr_cnt;
    pushBurst(0, 0, 0); pushBurst(2, 0, 0); pushBurst(0, 0, 0);
    pushBurst(2, 0, 0); pushBurst(0, 0, 0); pushBurst(2, 0, 0);
    repeat (7) step();
    checkOutput("cfg_err_set", 32'(config_err), 32'd1);
    enable = 1'b0;
    waitDrain(20, "drain_zero");
    repeat (5) step();
    checkOutput("zero_count", burst_count, 32'd6);
    checkOutput("zero_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
    checkOutput("zero_active", 32'(burst_active), 32'd0);

    $display("[TB] underrun");
    doReset();
    applyStimulus(1, 6, 16, 4'b0010, 1'b1);
    checkOutput("underrun_clear", 32'(underrun_err), 32'd0);
    pushBurst(1, 1, 6);
    base = hs_cnt;
    gap_base = gap_cnt;
    waitHs(base + 4, 100, "wait_mid_payload");
    src_valid_en[1] = 1'b0;
    repeat (3) step();
    src_valid_en[1] = 1'b1;
    waitDrain(100, "drain_underrun");
    enable = 1'b0;
    repeat (4) step();
    checkOutput("underrun_gap", 32'(gap_cnt - gap_base), 32'd3);
    checkOutput("underrun_sticky", 32'(underrun_err), 32'd1);
    checkOutput("underrun_count", burst_count, 32'd1);

    $display("[TB] reset mid-payload");
    applyStimulus(2, 10, 32, 4'b0100, 1'b1);
    pushBurst(2, 2, 10);
    base = hs_cnt;
    waitHs(base + 5, 100, "wait_reset_point");
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    clearModel();
    checkResetState("midrst");

    $display("[TB] enable dropped mid-burst");
    applyStimulus(2, 3, 16, 4'b1001, 1'b1);
    pushBurst(0, 2, 3);
    base = hs_cnt;
    waitHs(base + 2, 60, "wait_preamble");
    enable = 1'b0;
    waitDrain(50, "drain_disable");
    repeat (40) step();
    checkOutput("disable_count", burst_count, 32'd1);
    checkOutput("disable_grant", 32'(grant), 32'd0);
    checkOutput("disable_active", 32'(burst_active), 32'd0);
    checkOutput("disable_underrun", 32'(underrun_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
